// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encoding and
// synchronizer depth.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABILIZE  = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT_HOLD = 3'd4,
        ST_FAULT_RUN  = 3'd5
    } pll_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL LOCK pin into the
// oscillator clock domain. Both flops clear to 0 so that lock is never
// assumed present after reset.
module pll_lock_sync
    import pll_seq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw pin through the synchronizer chain, clearing on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: resets the PLL, waits for lock with a timeout and a
// bounded number of retries, requires lock to stay stable before releasing
// the design reset, and falls back to PLL bypass when lock is never reached.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17,
    parameter int RETRY_W       = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               relock,
    output logic               pll_resetb,
    output logic               pll_bypass,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retries,
    output logic [2:0]         state
);

    // Terminal counts: the counter is cleared on every transition and only
    // ever compared for equality, so it can never wrap.
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               lock_s;

    pll_lock_sync u_lock_sync (
        .clock  (clock),
        .reset  (reset),
        .async_i(pll_lock),
        .sync_o (lock_s)
    );

    // State, phase counter and retry counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= {CNT_W{1'b0}};
            retries_q <= {RETRY_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
        end
    end

    // Next-state logic; relock overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        if (relock) begin
            state_d   = ST_RESET_PLL;
            cnt_d     = {CNT_W{1'b0}};
            retries_d = {RETRY_W{1'b0}};
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_RESET_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (retries_q == RETRY_MAX) begin
                            state_d = ST_FAULT_HOLD;
                        end else begin
                            state_d   = ST_RESET_PLL;
                            retries_d = retries_q + RETRY_W'(1);
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABILIZE: begin
                    // A lock dropout restarts the lock wait without
                    // counting as a failed attempt.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = {CNT_W{1'b0}};
                        retries_d = {RETRY_W{1'b0}};
                    end else begin
                        state_d = ST_STABILIZE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_FAULT_HOLD: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = ST_FAULT_RUN;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_FAULT_HOLD;
                    end
                end
                ST_FAULT_RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        pll_resetb = 1'b0;
        pll_bypass = 1'b0;
        sys_reset  = 1'b1;
        ready      = 1'b0;
        fault      = 1'b0;
        case (state_q)
            ST_RESET_PLL: begin
                pll_resetb = 1'b0;
            end
            ST_WAIT_LOCK, ST_STABILIZE: begin
                pll_resetb = 1'b1;
            end
            ST_RUN: begin
                pll_resetb = 1'b1;
                sys_reset  = 1'b0;
                ready      = 1'b1;
            end
            ST_FAULT_HOLD: begin
                pll_bypass = 1'b1;
                fault      = 1'b1;
            end
            ST_FAULT_RUN: begin
                pll_bypass = 1'b1;
                fault      = 1'b1;
                sys_reset  = 1'b0;
            end
            default: begin
                pll_resetb = 1'b0;
            end
        endcase
    end

    assign retries = retries_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with fixed
// expected cycle numbers, then randomized lock/relock/reset traffic, with
// every cycle compared against a phase-duration reference model.
module tb_pll_lock_sequencer;

    localparam int RST  = 4;
    localparam int TO   = 20;
    localparam int STB  = 8;
    localparam int MAXR = 2;

    // Phase identifiers as the debug state output reports them.
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FH = 4, P_FR = 5;

    logic       clock = 1'b0;
    logic       reset, pll_lock, relock;
    logic       pll_resetb, pll_bypass, sys_reset, ready, fault;
    logic [1:0] retries;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: current phase, cycles spent in it, failed attempts,
    // and the last two pin values (lock is seen two cycles late).
    int m_ph, m_tm, m_rt;
    bit pin_d1, pin_d2;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(STB),
        .MAX_RETRIES  (MAXR),
        .CNT_W        (17),
        .RETRY_W      (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .relock    (relock),
        .pll_resetb(pll_resetb),
        .pll_bypass(pll_bypass),
        .sys_reset (sys_reset),
        .ready     (ready),
        .fault     (fault),
        .retries   (retries),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic enter(input int ph);
        m_ph = ph;
        m_tm = 0;
    endtask

    // One clock of the reference model; m_tm counts cycles already spent in
    // the current phase, so a phase of N cycles ends when m_tm reaches N.
    task automatic model_step(input bit l, input bit rl, input bit rs);
        bit ls;
        if (rs) begin
            enter(P_RST);
            m_rt   = 0;
            pin_d1 = 1'b0;
            pin_d2 = 1'b0;
        end else begin
            ls     = pin_d2;
            pin_d2 = pin_d1;
            pin_d1 = l;
            m_tm++;
            if (rl) begin
                enter(P_RST);
                m_rt = 0;
            end else begin
                case (m_ph)
                    P_RST:  if (m_tm == RST) enter(P_WAIT);
                    P_WAIT: begin
                        if (ls) enter(P_STAB);
                        else if (m_tm == TO) begin
                            if (m_rt == MAXR) enter(P_FH);
                            else begin
                                m_rt++;
                                enter(P_RST);
                            end
                        end
                    end
                    P_STAB: begin
                        if (!ls) enter(P_WAIT);
                        else if (m_tm == STB) begin
                            m_rt = 0;
                            enter(P_RUN);
                        end
                    end
                    P_RUN:  if (!ls) enter(P_RST);
                    P_FH:   if (m_tm == STB) enter(P_FR);
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] model_outs();
        bit run_like, flt;
        run_like = (m_ph == P_RUN) || (m_ph == P_FR);
        flt      = (m_ph == P_FH) || (m_ph == P_FR);
        return {22'd0, 3'(m_ph), 2'(m_rt),
                1'((m_ph == P_WAIT) || (m_ph == P_STAB) || (m_ph == P_RUN)),
                1'(flt), 1'(!run_like), 1'(m_ph == P_RUN), 1'(flt)};
    endfunction

    // Drive inputs for the current cycle, pass one active edge, then compare
    // all outputs mid-cycle.
    task automatic step(input bit l, input bit rl, input bit rs);
        pll_lock = l;
        relock   = rl;
        reset    = rs;
        model_step(l, rl, rs);
        @(negedge clock);
        cyc++;
        check_value("outputs", {22'd0, state, retries, pll_resetb, pll_bypass, sys_reset, ready, fault},
                    model_outs());
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        cyc = 0;
    endtask

    int base;
    bit rl_pin;

    initial begin
        reset = 1'b1; pll_lock = 1'b0; relock = 1'b0;
        m_ph = P_RST; m_tm = 0; m_rt = 0; pin_d1 = 1'b0; pin_d2 = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        cyc = 0;
        check_value("reset_vals", {22'd0, state, retries, pll_resetb, pll_bypass, sys_reset, ready, fault},
                    32'h0000_0004);

        // 1: normal lock, pin rises at cycle 10
        while (cyc < 30) begin
            step(cyc >= 10, 1'b0, 1'b0);
            if (cyc == 3)  check_value("t1_resetb_lo", {31'd0, pll_resetb}, 32'd0);
            if (cyc == 4)  check_value("t1_resetb_hi", {31'd0, pll_resetb}, 32'd1);
            if (cyc == 12) check_value("t1_wait", {29'd0, state}, 32'd1);
            if (cyc == 13) check_value("t1_stab", {29'd0, state}, 32'd2);
            if (cyc == 20) check_value("t1_notready", {31'd0, ready}, 32'd0);
            if (cyc == 21) check_value("t1_ready", {30'd0, ready, sys_reset}, 32'd2);
        end

        // 2: lock glitch during stabilization (pin low cycles 15-16)
        do_reset();
        while (cyc < 32) begin
            step((cyc >= 10) && !(cyc == 15 || cyc == 16), 1'b0, 1'b0);
            if (cyc == 18) check_value("t2_wait", {29'd0, state}, 32'd1);
            if (cyc == 20) check_value("t2_stab", {29'd0, state}, 32'd2);
            if (cyc == 25) check_value("t2_retries", {30'd0, retries}, 32'd0);
            if (cyc == 27) check_value("t2_notready", {31'd0, ready}, 32'd0);
            if (cyc == 28) check_value("t2_run", {29'd0, state}, 32'd3);
        end

        // 3: never locks -> fault fallback
        do_reset();
        while (cyc < 84) begin
            step(1'b0, 1'b0, 1'b0);
            if (cyc == 24) check_value("t3_retry1", {27'd0, state, retries}, 32'd1);
            if (cyc == 48) check_value("t3_retry2", {27'd0, state, retries}, 32'd2);
            if (cyc == 72) check_value("t3_fhold", {27'd0, state, pll_bypass, fault}, 32'h13);
            if (cyc == 79) check_value("t3_sys_hi", {31'd0, sys_reset}, 32'd1);
            if (cyc == 80) check_value("t3_frun", {27'd0, state, sys_reset, ready}, 32'h14);
        end

        // 5: relock from FAULT_RUN, then relock colliding with a timeout
        step(1'b0, 1'b1, 1'b0);
        check_value("t5_relock", {26'd0, state, pll_bypass, fault, retries, sys_reset}, 32'd1);
        base = cyc;
        while (cyc < base + RST + TO - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_value("t5_relock_to", {27'd0, state, retries}, 32'd0);
        base = cyc;
        while (cyc < base + RST + TO) step(1'b0, 1'b0, 1'b0);
        check_value("t5_next_to", {30'd0, retries}, 32'd1);

        // 4: lock loss in RUN, pin low cycles 40-44
        do_reset();
        while (cyc < 60) begin
            step((cyc >= 10) && !(cyc >= 40 && cyc < 45), 1'b0, 1'b0);
            if (cyc == 42) check_value("t4_still_run", {29'd0, state}, 32'd3);
            if (cyc == 43) check_value("t4_drop", {29'd0, sys_reset, ready, pll_resetb}, 32'd4);
            if (cyc == 46) check_value("t4_resetb_lo", {31'd0, pll_resetb}, 32'd0);
            if (cyc == 47) check_value("t4_resetb_hi", {31'd0, pll_resetb}, 32'd1);
            if (cyc == 56) check_value("t4_rerun", {27'd0, state, retries}, 32'h0c);
        end

        // 6: reset together with relock in STABILIZE
        do_reset();
        while (cyc < 15) step(cyc >= 10, 1'b0, 1'b0);
        check_value("t6_pre", {29'd0, state}, 32'd2);
        step(1'b1, 1'b1, 1'b1);
        check_value("t6_reset", {22'd0, state, retries, pll_resetb, pll_bypass, sys_reset, ready, fault},
                    32'h0000_0004);
        cyc = 0;
        while (cyc < 6) begin
            step(1'b1, 1'b0, 1'b0);
            if (cyc == 3) check_value("t6_resetb_lo", {31'd0, pll_resetb}, 32'd0);
            if (cyc == 4) check_value("t6_resetb_hi", {31'd0, pll_resetb}, 32'd1);
        end

        // Randomized traffic: sticky lock pin with occasional relock/reset.
        rl_pin = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rl_pin = ~rl_pin;
            step(rl_pin, $urandom_range(0, 199) == 0, $urandom_range(0, 599) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
